// File: rtl/pwm_led_sched.sv
// Four-channel LED PWM scheduler: shared prescaler/period counter, per-channel
// OFF/ON/BREATHE/BLINK duty sequencing, mode changes applied only at period ends.
module pwm_led_sched #(
  parameter int CLK_DIV       = 100,
  parameter int PWM_MAX       = 1000,
  parameter int BLINK_PERIODS = 250
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_rate,
  output logic       period_end,
  output logic [3:0] led
);
  localparam int NUM_CH = 4;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    PMAX     = 10'(PWM_MAX);
  localparam logic [9:0]    PLAST    = 10'(PWM_MAX - 1);
  localparam logic [10:0]   PMAX11   = 11'(PWM_MAX);
  localparam logic [BW-1:0] BLAST    = BW'(BLINK_PERIODS - 1);

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BREATHE, MODE_BLINK} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DONE} state_t;

  logic [DW-1:0] r_div;
  logic [9:0]    r_pwm;
  logic          r_period_end;
  logic [3:0]    r_led;
  logic          w_tick, w_pe;

  state_t        r_state, w_state_nxt;
  logic          w_accept, w_apply;
  logic [1:0]    r_cmd_ch, r_cmd_mode;
  logic [3:0]    r_cmd_rate;

  logic [NUM_CH-1:0][1:0]    r_mode, w_mode_nxt;
  logic [NUM_CH-1:0][9:0]    r_duty, w_duty_nxt;
  logic [NUM_CH-1:0]         r_dir, w_dir_nxt;
  logic [NUM_CH-1:0][3:0]    r_rate, w_rate_nxt;
  logic [NUM_CH-1:0][BW-1:0] r_bcnt, w_bcnt_nxt;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_pe       = w_tick && (r_pwm == PLAST);
  assign period_end = r_period_end;
  assign led        = r_led;
  assign cmd_ready  = (r_state == ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div        <= '0;
      r_pwm        <= '0;
      r_period_end <= 1'b0;
      r_led        <= '0;
    end else begin
      r_div        <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_pwm <= (r_pwm == PLAST) ? '0 : r_pwm + 1'b1;
      r_period_end <= w_pe;
      for (int i = 0; i < NUM_CH; i++) r_led[i] <= (r_pwm < r_duty[i]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd_ch   <= '0;
      r_cmd_mode <= '0;
      r_cmd_rate <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd_ch   <= cmd_ch;
        r_cmd_mode <= cmd_mode;
        r_cmd_rate <= cmd_rate;
      end
    end
  end

  // A command accepted on a pe cycle lands in PEND after that pe, so it waits for the next one.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: if (cmd_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_PEND;
      end
      ST_PEND: if (w_pe) begin
        w_apply     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_duty_nxt = r_duty;
    w_dir_nxt  = r_dir;
    w_rate_nxt = r_rate;
    w_bcnt_nxt = r_bcnt;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_apply && (r_cmd_ch == 2'(i))) begin
        w_mode_nxt[i] = r_cmd_mode;
        case (r_cmd_mode)
          MODE_OFF: w_duty_nxt[i] = 10'd0;
          MODE_ON:  w_duty_nxt[i] = PMAX;
          MODE_BREATHE: begin
            w_duty_nxt[i] = 10'd0;
            w_dir_nxt[i]  = 1'b0;
            w_rate_nxt[i] = r_cmd_rate;
          end
          default: begin
            w_duty_nxt[i] = PMAX;
            w_bcnt_nxt[i] = '0;
          end
        endcase
      end else if (w_pe) begin
        case (r_mode[i])
          MODE_OFF: w_duty_nxt[i] = 10'd0;
          MODE_ON:  w_duty_nxt[i] = PMAX;
          MODE_BREATHE: begin
            // Widened compare keeps duty+rate from wrapping near the top clamp.
            if (!r_dir[i]) begin
              if (({1'b0, r_duty[i]} + {7'd0, r_rate[i]}) >= PMAX11) begin
                w_duty_nxt[i] = PMAX;
                w_dir_nxt[i]  = 1'b1;
              end else begin
                w_duty_nxt[i] = r_duty[i] + {6'd0, r_rate[i]};
              end
            end else begin
              if (r_duty[i] <= {6'd0, r_rate[i]}) begin
                w_duty_nxt[i] = 10'd0;
                w_dir_nxt[i]  = 1'b0;
              end else begin
                w_duty_nxt[i] = r_duty[i] - {6'd0, r_rate[i]};
              end
            end
          end
          default: begin
            if (r_bcnt[i] == BLAST) begin
              w_bcnt_nxt[i] = '0;
              w_duty_nxt[i] = (r_duty[i] == 10'd0) ? PMAX : 10'd0;
            end else begin
              w_bcnt_nxt[i] = r_bcnt[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode <= '0;
      r_duty <= '0;
      r_dir  <= '0;
      r_rate <= '0;
      r_bcnt <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_duty <= w_duty_nxt;
      r_dir  <= w_dir_nxt;
      r_rate <= w_rate_nxt;
      r_bcnt <= w_bcnt_nxt;
    end
  end
endmodule

// File: tb/tb_pwm_led_sched.sv
// Bench for pwm_led_sched: period-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed per-period LED high counts.
module tb_pwm_led_sched;
  localparam int CD  = 2;
  localparam int PM  = 8;
  localparam int BP  = 2;
  localparam int PER = CD * PM;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_ch = '0;
  logic [1:0] cmd_mode = '0;
  logic [3:0] cmd_rate = '0;
  logic       period_end;
  logic [3:0] led;

  pwm_led_sched #(.CLK_DIV(CD), .PWM_MAX(PM), .BLINK_PERIODS(BP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_rate(cmd_rate),
    .period_end(period_end), .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: cycle index since reset release; each period has a fixed duty per channel.
  int m_cyc;
  int m_duty[4];
  int m_mode[4];
  int m_dir[4];
  int m_rate[4];
  int m_bcnt[4];
  int m_st;          // 0 idle, 1 pending, 2 done
  int p_ch, p_mode, p_rate;
  logic [3:0] m_led;
  logic       m_pe_out;

  always begin
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      m_cyc = 0; m_st = 0; m_led = '0; m_pe_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_duty[i] = 0; m_mode[i] = 0; m_dir[i] = 0; m_rate[i] = 0; m_bcnt[i] = 0;
      end
    end else begin
      int pos;
      bit pe;
      pos = m_cyc % PER;
      pe  = (pos == PER - 1);
      for (int i = 0; i < 4; i++) m_led[i] = ((pos / CD) < m_duty[i]);
      m_pe_out = pe;
      if (pe) begin
        for (int i = 0; i < 4; i++) begin
          if (m_st == 1 && i == p_ch) begin
            m_mode[i] = p_mode;
            case (p_mode)
              0: m_duty[i] = 0;
              1: m_duty[i] = PM;
              2: begin m_duty[i] = 0; m_dir[i] = 0; m_rate[i] = p_rate; end
              default: begin m_duty[i] = PM; m_bcnt[i] = 0; end
            endcase
          end else begin
            case (m_mode[i])
              0: m_duty[i] = 0;
              1: m_duty[i] = PM;
              2: begin
                if (m_dir[i] == 0) begin
                  if (m_duty[i] + m_rate[i] >= PM) begin m_duty[i] = PM; m_dir[i] = 1; end
                  else m_duty[i] += m_rate[i];
                end else begin
                  if (m_duty[i] <= m_rate[i]) begin m_duty[i] = 0; m_dir[i] = 0; end
                  else m_duty[i] -= m_rate[i];
                end
              end
              default: begin
                if (m_bcnt[i] == BP - 1) begin
                  m_bcnt[i] = 0;
                  m_duty[i] = (m_duty[i] == 0) ? PM : 0;
                end else m_bcnt[i]++;
              end
            endcase
          end
        end
      end
      case (m_st)
        0: if (cmd_valid) begin
          m_st = 1; p_ch = int'(cmd_ch); p_mode = int'(cmd_mode); p_rate = int'(cmd_rate);
        end
        1: if (pe) m_st = 2;
        default: m_st = 0;
      endcase
      m_cyc++;
    end
    #1;
    chk("led", int'(led), int'(m_led));
    chk("period_end", int'(period_end), int'(m_pe_out));
    chk("cmd_ready", int'(cmd_ready), int'(m_st == 0));
  end

  int cnt[16][4];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_pe();
    int n = 0;
    do begin tick(); n++; end while (!period_end && n < 3 * PER);
    if (!period_end) chk("wait_period_end_timeout", 0, 1);
  endtask

  // Counts led-high cycles per channel over nper full periods following the next period_end.
  task automatic measure(input int nper);
    for (int p = 0; p < 16; p++) for (int i = 0; i < 4; i++) cnt[p][i] = 0;
    wait_pe();
    for (int p = 0; p < nper; p++)
      for (int k = 0; k < PER; k++) begin
        tick();
        for (int i = 0; i < 4; i++) cnt[p][i] += int'(led[i]);
      end
  endtask

  task automatic wait_pos(input int k);
    int n = 0;
    while ((m_cyc % PER) != k && n < 3 * PER) begin tick(); n++; end
    if ((m_cyc % PER) != k) chk("wait_pos_timeout", m_cyc % PER, k);
  endtask

  task automatic send(input int ch, input int mode, input int rate);
    int n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (!cmd_ready) chk("send_ready_timeout", 0, 1);
    cmd_ch = 2'(ch); cmd_mode = 2'(mode); cmd_rate = 4'(rate);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int pulses, ledhi;
    int breathe_exp[8];
    int blink_exp[6];
    breathe_exp = '{0, 6, 12, 16, 10, 4, 0, 6};
    blink_exp   = '{16, 16, 0, 0, 16, 16};

    // 1: reset and idle
    tick(); tick();
    chk("rst_led", int'(led), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_period_end", int'(period_end), 0);
    sys_rst_n = 1'b1;
    pulses = 0; ledhi = 0;
    for (int k = 0; k < 3 * PER; k++) begin
      tick();
      pulses += int'(period_end);
      ledhi  += int'(led != 4'b0000);
      if (!cmd_ready) chk("idle_ready", 0, 1);
    end
    chk("idle_pulses", pulses, 3);
    chk("idle_led_high", ledhi, 0);

    // 2: ON to ch1
    send(1, 1, 0);
    chk("on_ready_low_after_accept", int'(cmd_ready), 0);
    measure(1);
    chk("on_ch0", cnt[0][0], 0);
    chk("on_ch1", cnt[0][1], PER);
    chk("on_ch2", cnt[0][2], 0);
    chk("on_ch3", cnt[0][3], 0);

    // 3: BREATHE ch0 rate 3
    send(0, 2, 3);
    measure(8);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("breathe_p%0d", p), cnt[p][0], breathe_exp[p]);
      chk($sformatf("breathe_ch1_p%0d", p), cnt[p][1], PER);
    end

    // 4: BLINK ch2
    send(2, 3, 0);
    measure(6);
    for (int p = 0; p < 6; p++) chk($sformatf("blink_p%0d", p), cnt[p][2], blink_exp[p]);

    // 5: ON to ch3 presented on the pe cycle, valid held into PEND
    wait_pos(PER - 1);
    chk("pe_cmd_ready", int'(cmd_ready), 1);
    cmd_ch = 2'd3; cmd_mode = 2'd1; cmd_rate = 4'd0;
    cmd_valid = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      cnt[p][3] = 0;
      for (int k = 0; k < PER; k++) begin
        tick();
        if (p == 0 && k == 4) cmd_valid = 1'b0;
        cnt[p][3] += int'(led[3]);
      end
    end
    chk("pe_cmd_not_same_period", cnt[0][3], 0);
    chk("pe_cmd_next_period", cnt[1][3], PER);

    // 6: reset during PEND of ch3 BREATHE
    wait_pos(2);
    send(3, 2, 2);
    tick(); tick();
    chk("pend_before_reset_ready", int'(cmd_ready), 0);
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_led", int'(led), 0);
    chk("async_rst_ready", int'(cmd_ready), 1);
    chk("async_rst_period_end", int'(period_end), 0);
    tick(); tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_led", int'(led), 0);
    measure(2);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) chk($sformatf("post_rst_p%0d_ch%0d", p, i), cnt[p][i], 0);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
